smi_header_inject_var: RTL and testbench

Injects a runtime-variable-length header (0 to HeadWidth bytes) at the start of each SMI frame, byte-shifting the frame body and adding an overflow tail flit when needed. It generalises the fixed-width partial-header injector: the header length is supplied per frame, so one instance serves protocols with different header sizes. It sits between a header generator and the SMI frame source, feeding a downstream SMI link through a registered output FIFO.

---
 rtl/smi_header_inject_var.sv | 226 ++++++++++++++++++++++
 tb/tb_smi_header_inject_var.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_header_inject_var.sv
// smi_header_inject_var
// Prepends a per-frame header of 0..HeadWidth bytes to each SMI frame.
// The frame body is byte-shifted by the header length. A tail flit is added
// when the shifted last flit spills past the flit width. Output flits are
// queued in a small FIFO that drives the downstream link.
module smi_header_inject_var #(
    parameter int FlitWidth     = 16,
    parameter int HeadWidth     = 8,
    parameter int FifoSize      = 16,
    parameter int FifoIndexSize = 4
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   headerReady,
    input  logic [7:0]             headerLen,
    input  logic [HeadWidth*8-1:0] headerData,
    output logic                   headerStop,
    input  logic                   smiInReady,
    input  logic [7:0]             smiInEofc,
    input  logic [FlitWidth*8-1:0] smiInData,
    output logic                   smiInStop,
    output logic                   smiOutReady,
    output logic [7:0]             smiOutEofc,
    output logic [FlitWidth*8-1:0] smiOutData,
    input  logic                   smiOutStop
);
    localparam int FlitBits = FlitWidth * 8;
    localparam int HeadBits = HeadWidth * 8;
    localparam int WideBits = 2 * FlitBits;
    localparam logic [7:0] FlitWidthB = 8'(FlitWidth);
    localparam logic [7:0] HeadWidthB = 8'(HeadWidth);
    localparam logic [7:0] EofcMask   = 8'(2 * FlitWidth - 1);
    localparam logic [FifoIndexSize:0]   FifoFull = (FifoIndexSize + 1)'(FifoSize);
    localparam logic [FifoIndexSize-1:0] PtrLast  = FifoIndexSize'(FifoSize - 1);

    typedef enum logic [1:0] {IDLE, COPY, TAIL} state_t;

    // ---------------------------------------------------------------------
    // Input register stages
    // ---------------------------------------------------------------------
    logic                headerReadyQ;
    logic [7:0]          headerLenQ;
    logic [HeadBits-1:0] headerDataQ;
    logic                headerHalt;

    logic                smiInReadyQ;
    logic [7:0]          smiInEofcQ;
    logic [FlitBits-1:0] smiInDataQ;
    logic                smiInHalt;

    assign headerStop = headerReadyQ & headerHalt;
    assign smiInStop  = smiInReadyQ & smiInHalt;

    // Header valid bit: reloads whenever the stage is not holding a stalled header
    always_ff @(posedge clk) begin
        if (srst)
            headerReadyQ <= 1'b0;
        else if (!headerStop)
            headerReadyQ <= headerReady;
    end

    // Header payload: length and bytes are captured in the same transfer
    always_ff @(posedge clk) begin
        if (!headerStop) begin
            headerLenQ  <= headerLen;
            headerDataQ <= headerData;
        end
    end

    // Flit valid bit
    always_ff @(posedge clk) begin
        if (srst)
            smiInReadyQ <= 1'b0;
        else if (!smiInStop)
            smiInReadyQ <= smiInReady;
    end

    // Flit payload; eofc is trimmed to its legal range on capture
    always_ff @(posedge clk) begin
        if (!smiInStop) begin
            smiInEofcQ <= smiInEofc & EofcMask;
            smiInDataQ <= smiInData;
        end
    end

    // ---------------------------------------------------------------------
    // Shift datapath
    // ---------------------------------------------------------------------
    logic [7:0]          lenClamped;
    logic [HeadBits-1:0] headMasked;
    logic [7:0]          shiftLen;
    logic [HeadBits-1:0] carry;
    logic [7:0]          tailEofc;
    logic [WideBits-1:0] shifted;
    logic [7:0]          eofcSum;

    assign lenClamped = (headerLenQ > HeadWidthB) ? HeadWidthB : headerLenQ;

    // Keep only the first L header bytes so unused bytes can never leak out
    always_comb begin
        headMasked = '0;
        for (int i = 0; i < HeadWidth; i++)
            if (8'(i) < lenClamped)
                headMasked[i*8 +: 8] = headerDataQ[i*8 +: 8];
    end

    // Low half is the output flit; the bytes pushed past the flit boundary
    // land in the upper half and become the next carry.
    assign shifted = (WideBits'(smiInDataQ) << {shiftLen, 3'b000}) | WideBits'(carry);
    assign eofcSum = smiInEofcQ + shiftLen;

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    state_t              state, nextState;
    logic                headerTake, flitTake, tailLatch;
    logic                fifoWrite, fifoRead, fifoStop;
    logic [7:0]          fifoWrEofc;
    logic [FlitBits-1:0] fifoWrData;

    // State register
    always_ff @(posedge clk) begin
        if (srst)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next-state, halts and FIFO write request
    always_comb begin
        nextState  = state;
        headerHalt = 1'b1;
        smiInHalt  = 1'b1;
        headerTake = 1'b0;
        flitTake   = 1'b0;
        tailLatch  = 1'b0;
        fifoWrite  = 1'b0;
        fifoWrEofc = 8'd0;
        fifoWrData = '0;
        case (state)
            IDLE: begin
                headerHalt = 1'b0;
                if (headerReadyQ) begin
                    headerTake = 1'b1;
                    nextState  = COPY;
                end
            end
            COPY: begin
                smiInHalt = fifoStop;
                if (smiInReadyQ && !fifoStop) begin
                    flitTake   = 1'b1;
                    fifoWrite  = 1'b1;
                    fifoWrData = shifted[FlitBits-1:0];
                    if (smiInEofcQ != 8'd0) begin
                        if (eofcSum > FlitWidthB) begin
                            tailLatch = 1'b1;
                            nextState = TAIL;
                        end else begin
                            fifoWrEofc = eofcSum;
                            nextState  = IDLE;
                        end
                    end
                end
            end
            TAIL: begin
                if (!fifoStop) begin
                    fifoWrite  = 1'b1;
                    fifoWrData = FlitBits'(carry);
                    fifoWrEofc = tailEofc;
                    nextState  = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Carry, shift length and tail eofc; data-path only, no reset needed
    always_ff @(posedge clk) begin
        if (headerTake) begin
            carry    <= headMasked;
            shiftLen <= lenClamped;
        end else if (flitTake) begin
            carry    <= shifted[FlitBits +: HeadBits];
        end
        if (tailLatch)
            tailEofc <= eofcSum - FlitWidthB;
    end

    // ---------------------------------------------------------------------
    // Output FIFO
    // ---------------------------------------------------------------------
    logic [FlitBits+7:0]    fifoMem [FifoSize];
    logic [FifoIndexSize-1:0] wrPtr, rdPtr;
    logic [FifoIndexSize:0]   fifoCount;

    assign fifoStop    = (fifoCount == FifoFull);
    assign smiOutReady = (fifoCount != '0);
    assign fifoRead    = smiOutReady & ~smiOutStop;
    assign {smiOutEofc, smiOutData} = fifoMem[rdPtr];

    // Storage array
    always_ff @(posedge clk) begin
        if (fifoWrite)
            fifoMem[wrPtr] <= {fifoWrEofc, fifoWrData};
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (srst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (fifoWrite)
                wrPtr <= (wrPtr == PtrLast) ? '0 : wrPtr + 1'b1;
            if (fifoRead)
                rdPtr <= (rdPtr == PtrLast) ? '0 : rdPtr + 1'b1;
            case ({fifoWrite, fifoRead})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
        end
    end

endmodule

// File: tb/tb_smi_header_inject_var.sv
// Scoreboard bench for smi_header_inject_var: stimulus pushes expected output
// flits into a queue, a negedge monitor pops and compares on every transfer.
module tb_smi_header_inject_var;
    localparam int FW = 16;
    localparam int HW = 8;
    localparam int FB = FW * 8;
    localparam int HB = HW * 8;

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic          headerReady = 1'b0;
    logic [7:0]    headerLen = 8'd0;
    logic [HB-1:0] headerData = '0;
    logic          headerStop;
    logic          smiInReady = 1'b0;
    logic [7:0]    smiInEofc = 8'd0;
    logic [FB-1:0] smiInData = '0;
    logic          smiInStop;
    logic          smiOutReady;
    logic [7:0]    smiOutEofc;
    logic [FB-1:0] smiOutData;
    logic          smiOutStop = 1'b0;

    smi_header_inject_var #(
        .FlitWidth(FW), .HeadWidth(HW), .FifoSize(16), .FifoIndexSize(4)
    ) dut (
        .clk(clk), .srst(srst),
        .headerReady(headerReady), .headerLen(headerLen), .headerData(headerData),
        .headerStop(headerStop),
        .smiInReady(smiInReady), .smiInEofc(smiInEofc), .smiInData(smiInData),
        .smiInStop(smiInStop),
        .smiOutReady(smiOutReady), .smiOutEofc(smiOutEofc), .smiOutData(smiOutData),
        .smiOutStop(smiOutStop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    eofc;
        logic [FB-1:0] data;
        string         tag;
    } exp_t;

    exp_t expQ[$];
    int   passCnt = 0;
    int   totalCnt = 0;
    bit   watchStall = 1'b0;
    bit   sawInStop;

    function automatic void check(string name, bit ok, string act, string req);
        totalCnt++;
        if (ok) passCnt++;
        else $display("FAIL %s: got %s, expected %s", name, act, req);
    endfunction

    function automatic void pushExp(string tag, logic [7:0] e, logic [FB-1:0] d);
        exp_t x;
        x.eofc = e;
        x.data = d;
        x.tag  = tag;
        expQ.push_back(x);
    endfunction

    // Reference: header bytes then body bytes as one stream, cut into flits
    task automatic pushFrame(string tag, int l, logic [HB-1:0] hd, logic [7:0] body[$]);
        logic [7:0]    s[$];
        logic [FB-1:0] d;
        int            n;
        for (int i = 0; i < l; i++) s.push_back(hd[i*8 +: 8]);
        foreach (body[i]) s.push_back(body[i]);
        for (int off = 0; off < s.size(); off += FW) begin
            n = (s.size() - off < FW) ? s.size() - off : FW;
            d = '0;
            for (int i = 0; i < n; i++) d[i*8 +: 8] = s[off + i];
            pushExp($sformatf("%s flit%0d", tag, off / FW), (off + n == s.size()) ? 8'(n) : 8'd0, d);
        end
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        exp_t          e;
        logic [FB-1:0] m;
        int            nb;
        if (!watchStall) sawInStop = 1'b0;
        else if (smiInStop) sawInStop = 1'b1;
        if (!srst && smiOutReady && !smiOutStop) begin
            if (expQ.size() == 0) begin
                check("unexpected output", 1'b0,
                      $sformatf("eofc=%0d data=%h", smiOutEofc, smiOutData), "no flit");
            end else begin
                e  = expQ.pop_front();
                nb = (e.eofc == 8'd0) ? FW : int'(e.eofc);
                m  = '0;
                for (int i = 0; i < nb && i < FW; i++) m[i*8 +: 8] = 8'hFF;
                check({e.tag, " eofc"}, smiOutEofc == e.eofc,
                      $sformatf("%0d", smiOutEofc), $sformatf("%0d", e.eofc));
                check({e.tag, " data"}, (smiOutData & m) == (e.data & m),
                      $sformatf("%h", smiOutData & m), $sformatf("%h", e.data & m));
            end
        end
    end

    task automatic sendHeader(input logic [7:0] len, input logic [HB-1:0] d);
        bit s;
        int g = 0;
        @(negedge clk);
        headerReady = 1'b1; headerLen = len; headerData = d;
        forever begin
            s = headerStop;
            @(posedge clk);
            if (!s) break;
            @(negedge clk);
            g++;
            if (g > 500) begin
                check("header handshake", 1'b0, "stuck", "transfer");
                break;
            end
        end
        @(negedge clk);
        headerReady = 1'b0;
    endtask

    task automatic sendFlit(input logic [7:0] e, input logic [FB-1:0] d);
        bit s;
        int g = 0;
        @(negedge clk);
        smiInReady = 1'b1; smiInEofc = e; smiInData = d;
        forever begin
            s = smiInStop;
            @(posedge clk);
            if (!s) break;
            @(negedge clk);
            g++;
            if (g > 500) begin
                check("flit handshake", 1'b0, "stuck", "transfer");
                break;
            end
        end
    endtask

    task automatic sendFrame(input logic [7:0] len, input logic [HB-1:0] hd, input logic [7:0] body[$]);
        logic [FB-1:0] d;
        int            n;
        sendHeader(len, hd);
        for (int off = 0; off < body.size(); off += FW) begin
            n = (body.size() - off < FW) ? body.size() - off : FW;
            d = '0;
            for (int i = 0; i < n; i++) d[i*8 +: 8] = body[off + i];
            sendFlit((off + n == body.size()) ? 8'(n) : 8'd0, d);
        end
        @(negedge clk);
        smiInReady = 1'b0;
    endtask

    task automatic drain(string tag);
        int g = 0;
        while (expQ.size() != 0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check({tag, " drained"}, expQ.size() == 0, $sformatf("%0d left", expQ.size()), "0 left");
    endtask

    function automatic void mkBody(output logic [7:0] q[$], input int n, input int base, input int step);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'(base + i * step));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] body[$];

        // Reset state
        repeat (3) @(negedge clk);
        check("reset headerStop", headerStop == 1'b0, $sformatf("%b", headerStop), "0");
        check("reset smiInStop", smiInStop == 1'b0, $sformatf("%b", smiInStop), "0");
        check("reset smiOutReady", smiOutReady == 1'b0, $sformatf("%b", smiOutReady), "0");
        srst = 1'b0;

        // 1: L=4, garbage above byte 3 of header must be masked
        mkBody(body, 24, 8'h00, 1);
        pushExp("s1 out0", 8'd0,  128'h0B0A0908_07060504_03020100_DDCCBBAA);
        pushExp("s1 out1", 8'd12, 128'h00000000_17161514_13121110_0F0E0D0C);
        sendFrame(8'd4, 64'h99999999_DDCCBBAA, body);
        drain("s1");

        // 2: L=8, single flit eofc 12 -> tail eofc 4
        mkBody(body, 12, 8'h20, 1);
        pushExp("s2 out0", 8'd0, 128'h27262524_23222120_88776655_44332211);
        pushExp("s2 out1", 8'd4, 128'h2B2A2928);
        sendFrame(8'd8, 64'h88776655_44332211, body);
        drain("s2");

        // 3: L=0 passthrough, last eofc 16
        mkBody(body, 48, 8'h50, 1);
        pushFrame("s3", 0, 64'hFFFFFFFF_FFFFFFFF, body);
        sendFrame(8'd0, 64'hFFFFFFFF_FFFFFFFF, body);
        drain("s3");

        // 4: headerLen 12 clamps to 8
        mkBody(body, 12, 8'h30, 1);
        pushExp("s4 out0", 8'd0, 128'h37363534_33323130_F8F7F6F5_F4F3F2F1);
        pushExp("s4 out1", 8'd4, 128'h3B3A3938);
        sendFrame(8'd12, 64'hF8F7F6F5_F4F3F2F1, body);
        drain("s4");

        // 5: 30-flit frame with output stalled for 40 cycles
        mkBody(body, 29 * 16 + 14, 3, 7);
        pushFrame("s5", 4, 64'h12345678_A4A3A2A1, body);
        @(posedge clk); #1;
        smiOutStop = 1'b1;
        watchStall = 1'b1;
        fork
            sendFrame(8'd4, 64'h12345678_A4A3A2A1, body);
            begin
                repeat (40) @(posedge clk);
                #1;
                check("s5 input backpressure seen", sawInStop == 1'b1, $sformatf("%b", sawInStop), "1");
                watchStall = 1'b0;
                smiOutStop = 1'b0;
            end
        join
        drain("s5");

        // 6: reset mid-frame with flits waiting in the FIFO
        @(posedge clk); #1;
        smiOutStop = 1'b1;
        sendHeader(8'd4, 64'h0000_0000_EEEEEEEE);
        for (int k = 0; k < 5; k++) sendFlit(8'd0, {16{8'(8'h70 + k)}});
        @(negedge clk);
        smiInReady = 1'b0;
        repeat (3) @(negedge clk);
        check("s6 fifo occupied before reset", smiOutReady == 1'b1, $sformatf("%b", smiOutReady), "1");
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        check("s6 post-reset smiOutReady", smiOutReady == 1'b0, $sformatf("%b", smiOutReady), "0");
        check("s6 post-reset headerStop", headerStop == 1'b0, $sformatf("%b", headerStop), "0");
        check("s6 post-reset smiInStop", smiInStop == 1'b0, $sformatf("%b", smiInStop), "0");
        @(posedge clk); #1;
        smiOutStop = 1'b0;
        mkBody(body, 31, 8'h40, 1);
        pushFrame("s6", 3, 64'h55555555_55C3C2C1, body);
        sendFrame(8'd3, 64'h55555555_55C3C2C1, body);
        drain("s6");

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
